dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the byte-addressed data memory. Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Selects one requester round-robin and translates its size/sign request into the memory's Load/Store encodings.
- Issues a one-cycle mRD/mWR strobe with a guaranteed low gap between strobes, because the memory reacts to strobe level changes.
- Captures read data and returns a one-cycle ack to the granted requester.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-addressed data memory.
// Optional misalignment rejection is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [1:0]        r0_size,
    input  logic              r0_uns,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [1:0]        r1_size,
    input  logic              r1_uns,
    output logic              r1_ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] DAddr,
    output logic [31:0]       DataIn,
    output logic [2:0]        Load,
    output logic [1:0]        Store,
    output logic              mRD,
    output logic              mWR,
    input  logic [31:0]       DataOut
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    localparam logic [ADDR_W:0] MemLimit = (ADDR_W+1)'(MEM_BYTES);

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              gnt_q;
    logic              we_q;
    logic              err_q;

    logic              any_req;
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [1:0]        extra;
    logic [ADDR_W:0]   last_byte;
    logic              range_err;
    logic              align_err;
    logic              sel_err;
    logic [2:0]        load_enc;
    logic [1:0]        store_enc;

    assign any_req = r0_req | r1_req;
    assign busy    = (state_q != StIdle);

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        sel_port = 1'b0;
        if (r0_req && r1_req) begin
            sel_port = ~last_grant_q;
        end else if (r1_req) begin
            sel_port = 1'b1;
        end
        sel_we    = sel_port ? r1_we    : r0_we;
        sel_addr  = sel_port ? r1_addr  : r0_addr;
        sel_wdata = sel_port ? r1_wdata : r0_wdata;
        sel_size  = sel_port ? r1_size  : r0_size;
        sel_uns   = sel_port ? r1_uns   : r0_uns;
    end

    always_comb begin
        case (sel_size)
            2'b00:   extra = 2'd0;
            2'b01:   extra = 2'd1;
            default: extra = 2'd3;
        endcase
        // One extra bit so an access straddling the top of the address space cannot wrap.
        last_byte = {1'b0, sel_addr} + {{(ADDR_W-1){1'b0}}, extra};
        range_err = (last_byte >= MemLimit);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        align_err = ((sel_size == 2'b01) && sel_addr[0]) ||
                    (sel_size[1] && (sel_addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        sel_err = range_err | align_err;
    end

    always_comb begin
        case (sel_size)
            2'b00:   load_enc = {2'b00, sel_uns};
            2'b01:   load_enc = {2'b01, sel_uns};
            default: load_enc = 3'b100;
        endcase
        case (sel_size)
            2'b00:   store_enc = 2'b00;
            2'b01:   store_enc = 2'b01;
            default: store_enc = 2'b10;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes, acks, rdata and err are single-cycle and default low every cycle;
    // the memory-side address/data/encodings hold until the next grant.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            DAddr        <= '0;
            DataIn       <= '0;
            Load         <= '0;
            Store        <= '0;
            mRD          <= 1'b0;
            mWR          <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
        end else begin
            state_q <= state_d;
            mRD     <= 1'b0;
            mWR     <= 1'b0;
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q        <= sel_port;
                        last_grant_q <= sel_port;
                        we_q         <= sel_we;
                        err_q        <= sel_err;
                        DAddr        <= sel_addr;
                        DataIn       <= sel_wdata;
                        Load         <= load_enc;
                        Store        <= store_enc;
                        mRD          <= ~sel_we & ~sel_err;
                        mWR          <= sel_we & ~sel_err;
                    end
                end
                StIssue: begin
                    r0_ack <= ~gnt_q;
                    r1_ack <= gnt_q;
                    err    <= err_q;
                    rdata  <= (!we_q && !err_q) ? DataOut : 32'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized accesses checked against a byte-array reference model.
module tb_dmem_arbiter;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned ADDR_W    = 32;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r0_uns = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0;
    logic [1:0]  r0_size = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0, r1_uns = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic [1:0]  r1_size = '0;
    logic        r0_ack, r1_ack, err, busy, mRD, mWR;
    logic [31:0] rdata, DAddr, DataIn;
    logic [31:0] DataOut;
    logic [2:0]  Load;
    logic [1:0]  Store;

    int n_chk  = 0;
    int n_pass = 0;
    int low_cnt = 100;

    logic [7:0] mem     [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    dmem_arbiter #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .r0_req  (r0_req),
        .r0_we   (r0_we),
        .r0_addr (r0_addr),
        .r0_wdata(r0_wdata),
        .r0_size (r0_size),
        .r0_uns  (r0_uns),
        .r0_ack  (r0_ack),
        .r1_req  (r1_req),
        .r1_we   (r1_we),
        .r1_addr (r1_addr),
        .r1_wdata(r1_wdata),
        .r1_size (r1_size),
        .r1_uns  (r1_uns),
        .r1_ack  (r1_ack),
        .rdata   (rdata),
        .err     (err),
        .busy    (busy),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .Load    (Load),
        .Store   (Store),
        .mRD     (mRD),
        .mWR     (mWR),
        .DataOut (DataOut)
    );

    always #5 CLK = ~CLK;

    // Memory device: combinational read while mRD, write on the edge ending the mWR cycle.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[DAddr[9:0]];
        b1 = mem[DAddr[9:0] + 10'd1];
        b2 = mem[DAddr[9:0] + 10'd2];
        b3 = mem[DAddr[9:0] + 10'd3];
        DataOut = 32'hDEAD_BEEF;
        if (mRD) begin
            case (Load)
                3'b000:  DataOut = {{24{b0[7]}}, b0};
                3'b001:  DataOut = {24'd0, b0};
                3'b010:  DataOut = {{16{b1[7]}}, b1, b0};
                3'b011:  DataOut = {16'd0, b1, b0};
                default: DataOut = {b3, b2, b1, b0};
            endcase
        end
    end

    always @(posedge CLK) begin
        if (mWR) begin
            mem[DAddr[9:0]] <= DataIn[7:0];
            if (Store != 2'b00) mem[DAddr[9:0] + 10'd1] <= DataIn[15:8];
            if (Store[1]) begin
                mem[DAddr[9:0] + 10'd2] <= DataIn[23:16];
                mem[DAddr[9:0] + 10'd3] <= DataIn[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (mRD || mWR) begin
            chk("strobe_gap", 32'(low_cnt >= 2), 32'd1);
            chk("strobe_busy", 32'(busy), 32'd1);
            low_cnt = 0;
        end else if (low_cnt < 1000) begin
            low_cnt++;
        end
        if (r0_ack || r1_ack) chk("ack_exclusive", 32'(r0_ack & r1_ack), 32'd0);
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
        logic e;
        e = (longint'(a) + longint'(nbytes(s)) - 1) >= longint'(MEM_BYTES);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if (nbytes(s) > 1 && (int'(a) % nbytes(s)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s,
                                             input logic u);
        longint v;
        int     n;
        n = nbytes(s);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[(int'(a) + i) % 1024]) << (8 * i));
        if (!u && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic drive(input logic p, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] s, input logic u);
        if (p) begin
            r1_req = req; r1_we = we; r1_addr = a; r1_wdata = wd; r1_size = s; r1_uns = u;
        end else begin
            r0_req = req; r0_we = we; r0_addr = a; r0_wdata = wd; r0_size = s; r0_uns = u;
        end
    endtask

    task automatic do_access(input string tag, input logic p, input logic we,
                             input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s,
                             input logic u, input logic [31:0] exp_rd, input logic exp_err);
        int   cyc;
        int   strobes;
        logic got;
        cyc = 0; strobes = 0; got = 1'b0;
        @(negedge CLK);
        drive(p, 1'b1, we, a, wd, s, u);
        while (!got && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
            if (mRD || mWR) begin
                strobes++;
                chk({tag, "_strobe_kind"}, 32'({mWR, mRD}), we ? 32'd2 : 32'd1);
                chk({tag, "_daddr"}, DAddr, a);
                if (we) begin
                    chk({tag, "_datain"}, DataIn, wd);
                    chk({tag, "_store"}, 32'(Store), (s >= 2'd2) ? 32'd2 : 32'(s));
                end else begin
                    chk({tag, "_load"}, 32'(Load), (s >= 2'd2) ? 32'd4 : 32'(s) * 2 + 32'(u));
                end
            end
            if (p ? r1_ack : r0_ack) begin
                got = 1'b1;
                chk({tag, "_latency"}, cyc, 32'd2);
                chk({tag, "_rdata"}, rdata, exp_rd);
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
                chk({tag, "_other_ack"}, 32'(p ? r0_ack : r1_ack), 32'd0);
            end
        end
        drive(p, 1'b0, we, a, wd, s, u);
        chk({tag, "_acked"}, 32'(got), 32'd1);
        chk({tag, "_strobes"}, strobes, exp_err ? 32'd0 : 32'd1);
        if (we && !exp_err)
            for (int i = 0; i < nbytes(s); i++) ref_mem[(int'(a) + i) % 1024] = wd[8 * i +: 8];
        @(posedge CLK);
    endtask

    // Both ports hold requests; acks must alternate starting with port 0.
    task automatic rr_run(input int n);
        int k;
        int cyc;
        k = 0; cyc = 0;
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
        while (k < n && cyc < 8 * n + 10) begin
            @(posedge CLK); #1;
            cyc++;
            if (r0_ack || r1_ack) begin
                chk("rr_order", 32'(r1_ack), 32'(k % 2));
                chk("rr_rdata", rdata, ref_read(r1_ack ? 32'h20 : 32'h10, 2'd2, 1'b0));
                k++;
                if (k == n) begin
                    r0_req = 1'b0;
                    r1_req = 1'b0;
                end
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        chk("rr_count", k, n);
        @(posedge CLK);
    endtask

    task automatic add(input logic p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] s, input logic u,
                       input logic [31:0] er, input logic ee);
        vec_t v;
        v.port = p; v.we = we; v.addr = a; v.wdata = wd; v.size = s; v.uns = u;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        p, we, u, ee;
        logic [31:0] a, wd, er;
        logic [1:0]  s;
        logic        seen;

        add(0, 1, 32'h10,  32'h8765_4321, 2'd2, 0, 32'h0000_0000, 0);
        add(0, 0, 32'h10,  32'h0,         2'd2, 0, 32'h8765_4321, 0);
        add(0, 0, 32'h10,  32'h0,         2'd0, 0, 32'h0000_0021, 0);
        add(0, 0, 32'h13,  32'h0,         2'd0, 0, 32'hFFFF_FF87, 0);
        add(0, 0, 32'h13,  32'h0,         2'd0, 1, 32'h0000_0087, 0);
        add(0, 0, 32'h12,  32'h0,         2'd1, 0, 32'hFFFF_8765, 0);
        add(0, 0, 32'h12,  32'h0,         2'd1, 1, 32'h0000_8765, 0);
        add(1, 0, 32'd1022, 32'h0,        2'd2, 0, 32'h0000_0000, 1);
        add(1, 0, 32'd1020, 32'h0,        2'd2, 0, 32'h0000_0000, 0);
        add(1, 1, 32'd1020, 32'hCAFE_F00D, 2'd3, 0, 32'h0000_0000, 0);
        add(1, 0, 32'd1020, 32'h0,        2'd2, 1, 32'hCAFE_F00D, 0);
        add(1, 0, 32'd1023, 32'h0,        2'd0, 0, 32'hFFFF_FFCA, 0);
        add(0, 1, 32'd1024, 32'h5555_5555, 2'd0, 0, 32'h0000_0000, 1);
        add(0, 0, 32'd1023, 32'h0,        2'd1, 1, 32'h0000_0000, 1);
        add(0, 1, 32'h20,  32'h1234_ABCD, 2'd1, 0, 32'h0000_0000, 0);
        add(0, 0, 32'h20,  32'h0,         2'd2, 0, 32'h0000_ABCD, 0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        add(0, 0, 32'h11,  32'h0,         2'd2, 0, 32'h0000_0000, 1);
`else
        add(0, 0, 32'h11,  32'h0,         2'd2, 0, 32'h0087_6543, 0);
`endif

        // Reset state, observed while reset is held.
        repeat (2) @(negedge CLK);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_strobe", 32'({mRD, mWR}), 32'd0);
        chk("rst_ack",   32'({r0_ack, r1_ack}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_daddr", DAddr, 32'd0);
        chk("rst_datain", DataIn, 32'd0);
        chk("rst_enc",   32'({Load, Store}), 32'd0);
        Reset = 1'b0;

        rr_run(4);

        for (int i = 0; i < vecs.size(); i++)
            do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].size, vecs[i].uns, vecs[i].exp_rdata,
                      vecs[i].exp_err);

        // Reset while a write strobe is in flight.
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h1122_3344, 2'd2, 1'b0);
        @(posedge CLK); #1;
        chk("abort_mwr_high", 32'(mWR), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("abort_mwr_low", 32'(mWR), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        r0_req = 1'b0;
        Reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            seen = seen | r0_ack | r1_ack;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        rr_run(2);
        do_access("abort_readback", 1'b0, 1'b0, 32'h40, 32'd0, 2'd2, 1'b0,
                  ref_read(32'h40, 2'd2, 1'b0), 1'b0);

        for (int i = 0; i < 40; i++) begin
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(1015, 1030));
            else a = 32'($urandom_range(0, 1023));
            ee = ref_err(a, s);
            er = (we || ee) ? 32'd0 : ref_read(a, s, u);
            do_access($sformatf("rnd%0d", i), p, we, a, wd, s, u, er, ee);
        end

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
